// File: rtl/cpu_types_pkg.sv
// Shared RV32I decode types: control-unit operation codes, opcode constants, skid-buffer entry.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
        CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI, CU_SLLI, CU_SRLI, CU_SRAI,
        CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
        CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
        CU_SB, CU_SH, CU_SW,
        CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
        CU_ERROR
    } cuop_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_state_t;

    // Decoded entry held in the skid buffer; all-zero is the reset value (op = CU_ADD).
    typedef struct packed {
        cuop_t       op;
        logic [19:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        illegal;
    } dec_entry_t;

endpackage

// File: rtl/instr_decoder.sv
// RV32I instruction decoder: raw word -> operation, packed immediate, register indices.
// Latency: purely combinational.
// Backpressure: none; consumer decides when to capture.
module instr_decoder
    import cpu_types_pkg::*;
(
    input  logic [31:0] inst,
    output cuop_t       cuop,
    output logic [19:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] imm_raw;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    always_comb begin
        cuop    = CU_ERROR;
        imm_raw = '0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  cuop = CU_ADD;
                        3'b001:  cuop = CU_SLL;
                        3'b010:  cuop = CU_SLT;
                        3'b011:  cuop = CU_SLTU;
                        3'b100:  cuop = CU_XOR;
                        3'b101:  cuop = CU_SRL;
                        3'b110:  cuop = CU_OR;
                        default: cuop = CU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    cuop = CU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    cuop = CU_SRA;
                end
            end
            OPC_OP_IMM: begin
                imm_raw = {8'b0, inst[31:20]};
                case (funct3)
                    3'b000:  cuop = CU_ADDI;
                    3'b010:  cuop = CU_SLTI;
                    3'b011:  cuop = CU_SLTIU;
                    3'b100:  cuop = CU_XORI;
                    3'b110:  cuop = CU_ORI;
                    3'b111:  cuop = CU_ANDI;
                    3'b001:  if (funct7 == F7_BASE) cuop = CU_SLLI;
                    default: begin
                        // funct3 101: shift amount shares imm bits with the SRL/SRA selector
                        if (funct7 == F7_BASE)     cuop = CU_SRLI;
                        else if (funct7 == F7_ALT) cuop = CU_SRAI;
                    end
                endcase
            end
            OPC_LUI: begin
                cuop    = CU_LUI;
                imm_raw = inst[31:12];
            end
            OPC_AUIPC: begin
                cuop    = CU_AUIPC;
                imm_raw = inst[31:12];
            end
            OPC_JAL: begin
                cuop    = CU_JAL;
                imm_raw = {inst[31], inst[19:12], inst[20], inst[30:21]};
            end
            OPC_JALR: begin
                imm_raw = {8'b0, inst[31:20]};
                if (funct3 == 3'b000) cuop = CU_JALR;
            end
            OPC_LOAD: begin
                imm_raw = {8'b0, inst[31:20]};
                case (funct3)
                    3'b000:  cuop = CU_LB;
                    3'b001:  cuop = CU_LH;
                    3'b010:  cuop = CU_LW;
                    3'b100:  cuop = CU_LBU;
                    3'b101:  cuop = CU_LHU;
                    default: cuop = CU_ERROR;
                endcase
            end
            OPC_STORE: begin
                imm_raw = {8'b0, inst[31:25], inst[11:7]};
                case (funct3)
                    3'b000:  cuop = CU_SB;
                    3'b001:  cuop = CU_SH;
                    3'b010:  cuop = CU_SW;
                    default: cuop = CU_ERROR;
                endcase
            end
            OPC_BRANCH: begin
                imm_raw = {8'b0, inst[31], inst[7], inst[30:25], inst[11:8]};
                case (funct3)
                    3'b000:  cuop = CU_BEQ;
                    3'b001:  cuop = CU_BNE;
                    3'b100:  cuop = CU_BLT;
                    3'b101:  cuop = CU_BGE;
                    3'b110:  cuop = CU_BLTU;
                    3'b111:  cuop = CU_BGEU;
                    default: cuop = CU_ERROR;
                endcase
            end
            default: cuop = CU_ERROR;
        endcase
    end

    assign illegal = (cuop == CU_ERROR);
    assign imm     = illegal ? 20'b0 : imm_raw;

endmodule

// File: rtl/decode_skid_stage.sv
// Decode stage with a 2-entry skid buffer of decoded fields and an illegal-instruction counter.
// Latency: one cycle; a push at edge N is on the outputs right after edge N.
// Backpressure: in_ready is a pure function of occupancy (low only when full), never of out_ready.
module decode_skid_stage
    import cpu_types_pkg::*;
#(
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output cuop_t                out_CUOp,
    output logic [19:0]          out_imm,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [31:0]          out_pc,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] illegal_count
);

    dec_entry_t in_entry;
    dec_entry_t head_q;
    dec_entry_t tail_q;
    occ_state_t state_q;
    occ_state_t state_d;
    logic       push;
    logic       pop;
    logic       load_head_new;
    logic       load_head_tail;
    logic       load_tail;

    instr_decoder u_dec (
        .inst    (in_inst),
        .cuop    (in_entry.op),
        .imm     (in_entry.imm),
        .rs1     (in_entry.rs1),
        .rs2     (in_entry.rs2),
        .rd      (in_entry.rd),
        .illegal (in_entry.illegal)
    );
    assign in_entry.pc = in_pc;

    assign in_ready  = (state_q != OCC_TWO);
    assign out_valid = (state_q != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= OCC_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        state_d       = OCC_ONE;
                        load_head_new = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        load_head_new = 1'b1;
                    end else if (push) begin
                        state_d   = OCC_TWO;
                        load_tail = 1'b1;
                    end else if (pop) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        state_d        = OCC_ONE;
                        load_head_tail = 1'b1;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_new)       head_q <= in_entry;
            else if (load_head_tail) head_q <= tail_q;
            if (load_tail)           tail_q <= in_entry;
        end
    end

    // A push discarded by flush must not be counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (push && !flush && in_entry.illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + 1'b1;
        end
    end

    assign out_CUOp    = head_q.op;
    assign out_imm     = head_q.imm;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_rd      = head_q.rd;
    assign out_pc      = head_q.pc;
    assign out_illegal = head_q.illegal;

endmodule

// File: doc/decode_skid_stage.md
DECODE_SKID_STAGE -- requirements
Module: decode_skid_stage

Interface
REQ-001 Parameter: ILL_CNT_W, default 8, width of the illegal-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 flush  in  1  discard all buffered entries (branch/jump redirect).
REQ-005 in_valid  in  1  fetch presents an instruction.
REQ-006 in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
REQ-007 in_inst  in  32  raw RV32I instruction word.
REQ-008 in_pc  in  32  PC of in_inst.
REQ-009 out_valid  out  1  head entry valid.
REQ-010 out_ready  in  1  downstream (sign extender / execute) consumes the head.
REQ-011 out_CUOp  out  cuop_t  decoded operation.
REQ-012 out_imm  out  20  raw immediate field, sign extender input format.
REQ-013 out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-014 out_pc  out  32  PC of the head entry.
REQ-015 out_illegal  out  1  head entry failed decode.
REQ-016 illegal_count  out  ILL_CNT_W  saturating count of accepted illegal instructions.

Function
REQ-017 Decode is combinational on in_inst; decoded fields, not raw words, are stored in a 2-entry FIFO (skid buffer).
REQ-018 Occupancy FSM states EMPTY, ONE, TWO; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-019 Transitions: EMPTY+push->ONE; ONE+push only->TWO; ONE+pop only->EMPTY; ONE+push+pop->ONE with new entry as head; TWO+pop->ONE; otherwise hold.
REQ-020 in_ready = 1 in EMPTY and ONE, 0 in TWO; out_valid = 1 in ONE and TWO.
REQ-021 Latency: an instruction pushed at edge N is visible on outputs after edge N; output fields remain stable while out_valid=1 and out_ready=0.
REQ-022 Entries leave in push order; no entry is dropped or duplicated except by flush/rst.
REQ-023 Immediate packing: I-type {8'b0, inst[31:20]}; S-type {8'b0, inst[31:25], inst[11:7]}; B-type {8'b0, inst[31], inst[7], inst[30:25], inst[11:8]}; U-type (LUI, AUIPC) inst[31:12]; J-type (JAL) {inst[31], inst[19:12], inst[20], inst[30:21]}; R-type 20'b0.
REQ-024 Opcode map: 0110011 R-ALU (funct3/funct7 select ADD, SUB, SLT, etc.); 0010011 I-ALU (ADDI, SLTI, etc.); 0110111 LUI; 0010111 AUIPC; 1101111 JAL; 1100111 JALR; 0000011 loads; 0100011 stores; 1100011 branches.
REQ-025 Unlisted opcode or illegal funct3/funct7 combination: CUOp = ERROR, out_illegal = 1, imm = 0; the entry still flows through normally.
REQ-026 illegal_count increments by 1 on each push of an illegal instruction and saturates at all-ones.
REQ-027 flush: next state EMPTY, any same-cycle push is discarded, and pop has no effect; illegal_count is not changed by flush and does not count a discarded push.

Reset
REQ-028 On rst, the FSM goes to EMPTY: out_valid=0, in_ready=1, illegal_count=0, and all stored fields (CUOp=ERROR-free default ADD, imm, rs*, rd, pc, illegal) are cleared to 0.
REQ-029 rst has priority over flush, push and pop; asserting rst mid-operation discards all contents.

Structure
REQ-030 cuop_t and opcode constants live in cpu_types_pkg; an ERROR value is added there if absent.
REQ-031 The decoder is one sub-module, instr_decoder (combinational, inst -> CUOp/imm/rs1/rs2/rd/illegal); the FIFO/FSM remains in decode_skid_stage.

Verification
REQ-032 Push ADDI x1,x0,-1 (0xFFF00093) with out_ready=1 -> one edge later out_CUOp=ADDI, out_imm=0x00FFF, out_rd=1, out_valid=1.
REQ-033 Push LUI then JAL with out_ready=0 -> after the second push in_ready=0; raising out_ready yields LUI then JAL on consecutive cycles; JAL 0x0080006F gives out_imm=0x00004.
REQ-034 Hold ONE state with push+pop every cycle for 10 instructions -> order preserved, in_ready stays 1, no bubbles.
REQ-035 Fill to TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed push never appears.
REQ-036 Push opcode 0x7F 300 times -> out_illegal=1, CUOp=ERROR each time, illegal_count saturates at 255; rst mid-stream clears the count to 0 and sets out_valid=0.
